// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: icache address/data, redirect request and the decode handshake.
// Member names follow the fetch unit's point of view (_o driven by fetch, _i driven towards it).
interface fetch_unit_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]  imem_addr_o;
  logic [INSTR_WIDTH-1:0] imem_data_i;
  logic                   redirect_i;
  logic [ADDR_WIDTH-1:0]  redirect_pc_i;
  logic                   instr_valid_o;
  logic                   instr_ready_i;
  logic [INSTR_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0]  instr_pc_o;

  modport master (
    input  imem_data_i, redirect_i, redirect_pc_i, instr_ready_i,
    output imem_addr_o, instr_valid_o, instr_o, instr_pc_o
  );

  modport slave (
    output imem_data_i, redirect_i, redirect_pc_i, instr_ready_i,
    input  imem_addr_o, instr_valid_o, instr_o, instr_pc_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads the icache (1-cycle data), buffers {pc, instr} in 2 entries.
// Address in t, data in t+1, valid in t+2; issue stops when buffer plus in-flight read would exceed 2.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;
  logic                  r_inflight;
  entry_t                r_mem [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;
  entry_t                r_last;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [2:0]            w_need;
  entry_t                w_head;

  assign w_head = r_mem[r_rd_ptr];
  assign w_pop  = (r_count != 2'd0) && bus.instr_ready_i;
  assign w_push = r_inflight && !bus.redirect_i;
  // Slots claimed if we issue now: buffered + in flight + the new read, less what leaves this cycle.
  assign w_need  = {1'b0, r_count} + {2'b00, r_inflight} + 3'd1;
  assign w_issue = !bus.redirect_i && (w_need <= (3'd2 + {2'b00, w_pop}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (bus.redirect_i) begin
      r_fetch_pc <= {bus.redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_fetch_pc;
      r_fetch_pc    <= r_fetch_pc + ADDR_WIDTH'(4);
    end else begin
      r_inflight <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_last   <= '0;
    end else begin
      // Remember what decode last saw so the outputs hold once the buffer drains or is flushed.
      if (r_count != 2'd0) r_last <= w_head;
      if (bus.redirect_i) begin
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
        r_count  <= 2'd0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= '{pc: r_inflight_pc, instr: bus.imem_data_i};
          r_wr_ptr        <= ~r_wr_ptr;
        end
        if (w_pop) r_rd_ptr <= ~r_rd_ptr;
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  assign bus.imem_addr_o   = r_fetch_pc;
  assign bus.instr_valid_o = (r_count != 2'd0);
  assign bus.instr_o       = (r_count != 2'd0) ? w_head.instr : r_last.instr;
  assign bus.instr_pc_o    = (r_count != 2'd0) ? w_head.pc    : r_last.pc;

  assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_count == 2'd2)));
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a PC-stream model.
// The icache model returns addr ^ 32'hA5A5_0000 one cycle after the address.
module tb_fetch_unit;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  fetch_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.imem_data_i <= bus.imem_addr_o ^ XORK;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.instr_ready_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.imem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr_o, 32'h0); end
    checks++; if (bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.instr_valid_o); end
    checks++; if (bus.instr_o !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.instr_o); end
    checks++; if (bus.instr_pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus.instr_pc_o); end
  endtask

  task automatic test_startup();
    rst_n = 1'b1;
    bus.instr_ready_i = 1'b1;
    checks++; if (bus.imem_addr_o !== 32'h0) begin failures++; $display("FAIL start_addr0 got=%h exp=0", bus.imem_addr_o); end
    checks++; if (bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL start_valid0 got=%b exp=0", bus.instr_valid_o); end
    tick();
    checks++; if (bus.imem_addr_o !== 32'h4) begin failures++; $display("FAIL start_addr1 got=%h exp=4", bus.imem_addr_o); end
    checks++; if (bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL start_valid1 got=%b exp=0", bus.instr_valid_o); end
    tick();
    checks++; if (bus.imem_addr_o !== 32'h8) begin failures++; $display("FAIL start_addr2 got=%h exp=8", bus.imem_addr_o); end
    checks++; if (bus.instr_valid_o !== 1'b1) begin failures++; $display("FAIL start_valid2 got=%b exp=1", bus.instr_valid_o); end
    checks++; if (bus.instr_pc_o !== 32'h0) begin failures++; $display("FAIL start_pc got=%h exp=0", bus.instr_pc_o); end
    checks++; if (bus.instr_o !== XORK) begin failures++; $display("FAIL start_instr got=%h exp=%h", bus.instr_o, XORK); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'(4 * i) || bus.instr_o !== (32'(4 * i) ^ XORK)) begin
        failures++;
        $display("FAIL stream v=%b pc=%h instr=%h exp_pc=%h", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    bus.instr_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h10 || bus.instr_o !== (32'h10 ^ XORK)) begin
        failures++;
        $display("FAIL stall_hold v=%b pc=%h instr=%h exp_pc=10", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o);
      end
      checks++;
      if (bus.imem_addr_o !== 32'h18) begin failures++; $display("FAIL stall_addr got=%h exp=18", bus.imem_addr_o); end
      tick();
    end
    bus.instr_ready_i = 1'b1;
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'(32'h10 + 4 * j) || bus.instr_o !== (32'(32'h10 + 4 * j) ^ XORK)) begin
        failures++;
        $display("FAIL stall_resume v=%b pc=%h exp_pc=%h", bus.instr_valid_o, bus.instr_pc_o, 32'(32'h10 + 4 * j));
      end
      tick();
    end
  endtask

  // Drive a redirect for one cycle, check the two-cycle bubble, then expect n pcs from target.
  task automatic redirect_and_expect(input logic [31:0] tgt, input logic [31:0] first_pc, input int n);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = tgt;
    tick();
    bus.redirect_i = 1'b0;
    checks++; if (bus.imem_addr_o !== first_pc) begin failures++; $display("FAIL redir_addr got=%h exp=%h", bus.imem_addr_o, first_pc); end
    checks++; if (bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL redir_r1_valid got=%b exp=0", bus.instr_valid_o); end
    tick();
    checks++; if (bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL redir_r2_valid got=%b exp=0", bus.instr_valid_o); end
    bus.instr_ready_i = 1'b1;
    tick();
    for (int j = 0; j < n; j++) begin
      checks++;
      if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'(first_pc + 4 * j) || bus.instr_o !== (32'(first_pc + 4 * j) ^ XORK)) begin
        failures++;
        $display("FAIL redir_stream v=%b pc=%h instr=%h exp_pc=%h", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o, 32'(first_pc + 4 * j));
      end
      tick();
    end
  endtask

  task automatic test_redirect_full();
    bus.instr_ready_i = 1'b0;
    repeat (3) tick();
    redirect_and_expect(32'h200, 32'h200, 4);
  endtask

  task automatic test_back_to_back();
    bus.instr_ready_i = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h300;
    tick();
    redirect_and_expect(32'h400, 32'h400, 3);
  endtask

  task automatic test_misaligned();
    redirect_and_expect(32'h102, 32'h100, 2);
  endtask

  task automatic test_wrap();
    redirect_and_expect(32'hFFFF_FFF8, 32'hFFFF_FFF8, 3);
  endtask

  task automatic test_async_reset();
    bus.instr_ready_i = 1'b1;
    repeat (2) tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", bus.instr_valid_o); end
    checks++; if (bus.imem_addr_o !== 32'h0) begin failures++; $display("FAIL areset_addr got=%h exp=0", bus.imem_addr_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h0 || bus.instr_o !== XORK) begin
      failures++;
      $display("FAIL areset_restart v=%b pc=%h instr=%h exp_pc=0", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o);
    end
    tick();
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h4) begin
      failures++;
      $display("FAIL areset_next v=%b pc=%h exp_pc=4", bus.instr_valid_o, bus.instr_pc_o);
    end
  endtask

  // Model: decode sees one linear pc stream, restarted at each aligned redirect target.
  task automatic test_random();
    logic [31:0] exp_pc, prev_pc, prev_instr, tgt;
    logic        rdy, rd, prev_stall;
    int          age, delivered;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h1000;
    bus.instr_ready_i = 1'b0;
    exp_pc     = 32'h1000;
    age        = 0;
    delivered  = 0;
    prev_stall = 1'b0;
    prev_pc    = '0;
    prev_instr = '0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      age++;
      if (age == 1 || age == 2) begin
        checks++; if (bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL rnd_bubble cyc=%0d v=%b exp=0", c, bus.instr_valid_o); end
      end
      if (age == 3) begin
        checks++; if (bus.instr_valid_o !== 1'b1) begin failures++; $display("FAIL rnd_first cyc=%0d v=%b exp=1", c, bus.instr_valid_o); end
      end
      if (prev_stall) begin
        checks++;
        if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== prev_pc || bus.instr_o !== prev_instr) begin
          failures++;
          $display("FAIL rnd_stable cyc=%0d v=%b pc=%h instr=%h exp_pc=%h exp_instr=%h", c, bus.instr_valid_o, bus.instr_pc_o, bus.instr_o, prev_pc, prev_instr);
        end
      end
      checks++; if (bus.imem_addr_o[1:0] !== 2'b00) begin failures++; $display("FAIL rnd_align cyc=%0d addr=%h", c, bus.imem_addr_o); end

      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom();
      bus.instr_ready_i = rdy;
      bus.redirect_i    = rd;
      bus.redirect_pc_i = tgt;

      if (bus.instr_valid_o === 1'b1 && rdy) begin
        checks++;
        if (bus.instr_pc_o !== exp_pc || bus.instr_o !== (exp_pc ^ XORK)) begin
          failures++;
          $display("FAIL rnd_deliver cyc=%0d pc=%h instr=%h exp_pc=%h exp_instr=%h", c, bus.instr_pc_o, bus.instr_o, exp_pc, exp_pc ^ XORK);
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      prev_stall = (bus.instr_valid_o === 1'b1) && !rdy && !rd;
      prev_pc    = bus.instr_pc_o;
      prev_instr = bus.instr_o;
      if (rd) begin
        exp_pc = {tgt[31:2], 2'b00};
        age    = 0;
      end
      tick();
    end
    bus.redirect_i = 1'b0;
    checks++; if (delivered < 500) begin failures++; $display("FAIL rnd_progress delivered=%0d exp>=500", delivered); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect_full();
    test_back_to_back();
    test_misaligned();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
